// File: rtl/z80_bus_initiator.sv
// z80_bus_initiator: turns request/response transactions into Z80 bus cycles
// (M1 fetch, memory read/write, I/O read/write), one T-state per CLK.
// Handles nWAIT wait states and aborts after 256 consecutive TW states.
// Build option: define Z80_REFRESH_EN to drive a DRAM refresh address from a
// 7-bit R counter in fetch T3/T4.
module z80_bus_initiator (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic [2:0]  REQ_TYPE,
   input  logic [15:0] REQ_ADDR,
   input  logic [7:0]  REQ_WDATA,
   output logic        RSP_VALID,
   output logic [7:0]  RSP_RDATA,
   output logic        RSP_ERR,
   output logic [15:0] A,
   output logic [7:0]  D_OUT,
   output logic        D_OE,
   input  logic [7:0]  D_IN,
   input  logic        nWAIT,
   output logic        nMREQ,
   output logic        nIORQ,
   output logic        nRD,
   output logic        nWR,
   output logic        nM1,
   output logic        nRFSH
);

   typedef enum logic [2:0] {StIdle, StT1, StT2, StTwa, StTw, StT3, StT4} state_t;

   state_t      state_q, state_d;
   logic [2:0]  typ_q, typ_n;
   logic [15:0] addr_q, addr_n;
   logic [7:0]  wdata_q, wdata_n;
   logic [7:0]  rdata_q;
   logic [7:0]  wait_cnt_q;
   logic        accept, done, abort;
   logic        is_fetch, is_mem, is_io, is_rd, is_wr, is_rsvd;
   logic [15:0] a_d;
   logic [7:0]  dout_d;
   logic        doe_d, mreq_n_d, iorq_n_d, rd_n_d, wr_n_d, m1_n_d, rfsh_n_d;
`ifdef Z80_REFRESH_EN
   logic [6:0]  r_q;
`endif

   assign REQ_READY = (state_q == StIdle) && !RST;
   assign accept    = (state_q == StIdle) && REQ_VALID;

   // The T1 outputs are computed on the accept edge, before the latches load.
   assign typ_n   = accept ? REQ_TYPE  : typ_q;
   assign addr_n  = accept ? REQ_ADDR  : addr_q;
   assign wdata_n = accept ? REQ_WDATA : wdata_q;

   assign is_fetch = (typ_n == 3'd0);
   assign is_mem   = (typ_n == 3'd1) || (typ_n == 3'd2);
   assign is_io    = (typ_n == 3'd3) || (typ_n == 3'd4);
   assign is_rd    = (typ_n == 3'd1) || (typ_n == 3'd3);
   assign is_wr    = (typ_n == 3'd2) || (typ_n == 3'd4);
   assign is_rsvd  = (typ_n > 3'd4);

   // Next T-state; done marks a normal final T-state, abort a wait timeout.
   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      abort   = 1'b0;
      unique case (state_q)
         StIdle: if (REQ_VALID) state_d = StT1;
         StT1:   state_d = StT2;
         StT2: begin
            if (is_io)                    state_d = StTwa;
            else if (!is_rsvd && !nWAIT)  state_d = StTw;
            else                          state_d = StT3;
         end
         StTwa:  state_d = nWAIT ? StT3 : StTw;
         StTw: begin
            if (nWAIT) begin
               state_d = StT3;
            end else if (wait_cnt_q == 8'hFF) begin
               state_d = StIdle;
               abort   = 1'b1;
            end
         end
         StT3: begin
            if (is_fetch) begin
               state_d = StT4;
            end else begin
               state_d = StIdle;
               done    = 1'b1;
            end
         end
         StT4: begin
            state_d = StIdle;
            done    = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   // Bus values for the T-state being entered; registered below.
   always_comb begin
      a_d      = A;
      dout_d   = D_OUT;
      doe_d    = 1'b0;
      mreq_n_d = 1'b1;
      iorq_n_d = 1'b1;
      rd_n_d   = 1'b1;
      wr_n_d   = 1'b1;
      m1_n_d   = 1'b1;
      rfsh_n_d = 1'b1;
      unique case (state_d)
         StIdle: ;
         StT1: begin
            a_d    = addr_n;
            m1_n_d = !is_fetch;
            doe_d  = is_wr;
            if (is_wr) dout_d = wdata_n;
         end
         StT2, StTwa, StTw: begin
            a_d      = addr_n;
            doe_d    = is_wr;
            mreq_n_d = !(is_fetch || is_mem);
            iorq_n_d = !is_io;
            rd_n_d   = !(is_fetch || is_rd);
            wr_n_d   = !is_wr;
            m1_n_d   = !is_fetch;
         end
         StT3: begin
            if (is_fetch) begin
`ifdef Z80_REFRESH_EN
               a_d      = {9'b0, r_q};
               mreq_n_d = 1'b0;
               rfsh_n_d = 1'b0;
`else
               a_d      = addr_n;
`endif
            end else begin
               a_d      = addr_n;
               doe_d    = is_wr;
               mreq_n_d = !is_mem;
               iorq_n_d = !is_io;
               rd_n_d   = !is_rd;
               wr_n_d   = !is_wr;
            end
         end
         StT4: begin
`ifdef Z80_REFRESH_EN
            rfsh_n_d = 1'b0;
`else
            a_d      = addr_n;
`endif
         end
         default: ;
      endcase
   end

   // State, request latches, registered bus outputs and the response pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= StIdle;
         typ_q      <= 3'd0;
         addr_q     <= 16'h0000;
         wdata_q    <= 8'h00;
         rdata_q    <= 8'h00;
         wait_cnt_q <= 8'h00;
         A          <= 16'h0000;
         D_OUT      <= 8'h00;
         D_OE       <= 1'b0;
         nMREQ      <= 1'b1;
         nIORQ      <= 1'b1;
         nRD        <= 1'b1;
         nWR        <= 1'b1;
         nM1        <= 1'b1;
         nRFSH      <= 1'b1;
         RSP_VALID  <= 1'b0;
         RSP_RDATA  <= 8'h00;
         RSP_ERR    <= 1'b0;
`ifdef Z80_REFRESH_EN
         r_q        <= 7'd0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            typ_q   <= REQ_TYPE;
            addr_q  <= REQ_ADDR;
            wdata_q <= REQ_WDATA;
         end
         wait_cnt_q <= (state_q == StTw && state_d == StTw) ? wait_cnt_q + 8'd1 : 8'h00;
         // Fetch data is taken on the edge leaving the last T2/TW.
         if (is_fetch && (state_q == StT2 || state_q == StTw) && state_d == StT3) begin
            rdata_q <= D_IN;
         end
         A     <= a_d;
         D_OUT <= dout_d;
         D_OE  <= doe_d;
         nMREQ <= mreq_n_d;
         nIORQ <= iorq_n_d;
         nRD   <= rd_n_d;
         nWR   <= wr_n_d;
         nM1   <= m1_n_d;
         nRFSH <= rfsh_n_d;
         RSP_VALID <= done || abort;
         if (abort) begin
            RSP_RDATA <= 8'hFF;
            RSP_ERR   <= 1'b1;
         end else if (done) begin
            RSP_ERR   <= is_rsvd;
            RSP_RDATA <= is_fetch ? rdata_q : (is_rd ? D_IN : 8'hFF);
         end
`ifdef Z80_REFRESH_EN
         if (done && is_fetch) r_q <= r_q + 7'd1;
`endif
      end
   end

endmodule

// File: doc/z80_bus_initiator.md
Z80_BUS_INITIATOR -- requirements
Module: z80_bus_initiator

Interface
REQ-001 SHALL provide ports: CLK  in  1  single clock, one CLK period = one Z80 T-state; all logic on rising edge.
REQ-002 SHALL provide: RST  in  1  synchronous, active-high reset.
REQ-003 SHALL provide: REQ_VALID in 1, REQ_READY out 1  request handshake; transfer when both high on a CLK edge.
REQ-004 SHALL provide: REQ_TYPE in 3  0=opcode fetch (M1), 1=mem read, 2=mem write, 3=I/O read, 4=I/O write, 5-7 reserved.
REQ-005 SHALL provide: REQ_ADDR in 16, REQ_WDATA in 8  cycle address, write data.
REQ-006 SHALL provide: RSP_VALID out 1, RSP_RDATA out 8, RSP_ERR out 1  one-clock completion pulse, read data, abort flag.
REQ-007 SHALL provide Z80 bus side: A out 16, D_OUT out 8, D_OE out 1 (active-high drive enable), D_IN in 8, nWAIT in 1.
REQ-008 SHALL provide strobes, all out 1, active low: nMREQ, nIORQ, nRD, nWR, nM1, nRFSH.

Function
REQ-009 SHALL implement states IDLE, T1, T2, TWA (automatic I/O wait), TW, T3, T4; all bus outputs registered.
REQ-010 REQ_READY SHALL be high only in IDLE; on accept, type/addr/wdata latched and next state is T1.
REQ-011 T1: A=latched address, all strobes high except nM1=0 for fetch; write types drive D_OUT=wdata, D_OE=1 from T1 through T3.
REQ-012 T2, TW, T3: nMREQ (memory/fetch) or nIORQ (I/O) low, plus nRD (reads/fetch) or nWR (writes) low; nM1 stays low for fetch through T2/TW.
REQ-013 nWAIT SHALL be sampled on the edge ending T2 (memory/fetch) or TWA (I/O); 0 -> TW; sampled again at end of each TW.
REQ-014 I/O cycles SHALL always insert exactly one TWA after T2, before any nWAIT-driven TW.
REQ-015 Fetch: D_IN captured on edge ending last T2/TW; T3, T4 are refresh T-states; nM1, nRD high in T3/T4.
REQ-016 Mem/I/O read: D_IN captured on edge ending T3; fetch totals 4+n T-states, memory 3+n, I/O 4+n (n = TW count).
REQ-017 All strobes SHALL be high and D_OE=0 in the first clock after the final T-state (IDLE), guaranteeing a clean nMREQ/nIORQ rising edge per cycle.
REQ-018 RSP_VALID SHALL pulse exactly one clock in that IDLE clock, RSP_RDATA = captured data (reads) or 8'hFF (writes, reserved, abort).
REQ-019 Reserved types SHALL be accepted and run 3 T-states with no strobes asserted, then RSP_VALID with RSP_ERR=1.
REQ-020 An 8-bit wait counter SHALL count consecutive TW states; on the 256th, cycle aborts: strobes high next clock, IDLE, RSP_VALID with RSP_ERR=1.
REQ-021 Minimum spacing between consecutive cycles SHALL be one IDLE clock; REQ_VALID held high yields back-to-back cycles with exactly one IDLE gap.

Reset
REQ-022 RST SHALL force within one clock, including mid-cycle: state IDLE, A=0, D_OUT=0, D_OE=0, all strobes 1, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, wait counter 0, refresh counter 0.
REQ-023 REQ_READY SHALL be 0 while RST is high and 1 on the first clock after RST deasserts; an aborted cycle produces no RSP_VALID.

Configuration
REQ-024 Macro Z80_REFRESH_EN defined: T3 drives A={9'b0,R[6:0]}, nRFSH=0, nMREQ=0; T4 keeps A and nRFSH=0, nMREQ=1; 7-bit R increments (mod 128) at end of each fetch.
REQ-025 Z80_REFRESH_EN undefined: T3/T4 keep fetch address on A, nMREQ=nRFSH=1 constantly, no R counter; fetch T-state count unchanged.

Verification
REQ-026 Fetch 0x0000, nWAIT=1 -> nM1 and nMREQ/nRD low together in T2, 4 T-states, RSP_RDATA=D_IN, clean nMREQ rise before RSP_VALID.
REQ-027 I/O write addr 0x003F, data 0xA5, nWAIT=1 -> nIORQ/nWR low for T2+TWA+T3 (3 clocks), D_OE=1 T1-T3, D_OUT=0xA5, RSP_ERR=0.
REQ-028 Mem read 0x0604, nWAIT low 2 clocks -> 2 TW inserted, 5 T-states total, data captured at end of T3.
REQ-029 nWAIT held low -> abort after 256 TW, strobes high next clock, RSP_ERR=1, RSP_RDATA=0xFF.
REQ-030 RST asserted during I/O read TWA -> next clock all strobes high, D_OE=0, no RSP_VALID; then Z80_REFRESH_EN build: 3 fetches -> refresh A[6:0]=0,1,2.
